mem_arbiter: RTL

Two-port arbiter that shares the single memory management unit between the instruction-fetch unit and the load/store (data) unit. It latches one request at a time, drives the MMU read/write strobes with the level/edge discipline the MMU needs, routes the completion pulse and read data back to the owning requester, and aborts transfers that never complete. It sits between the CPU core's fetch/execute stages and the MMU.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types and default widths.
// Imported by the arbiter top and its round-robin picker.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 24;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way round-robin selector; on a tie the port
// that did not win last time is chosen.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   f_req,
  input  logic   d_req,
  input  owner_t last,
  output logic   grant_valid,
  output owner_t owner
);

  always_comb begin
    grant_valid = f_req | d_req;
    owner       = OWN_FETCH;
    unique case (1'b1)
      (f_req && d_req):
        owner = (last == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
      (d_req && !f_req):
        owner = OWN_DATA;
      default:
        owner = OWN_FETCH;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one MMU between fetch and load/store units,
// one latched transfer at a time, with a watchdog abort.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [1:0]        f_bytes,
  output logic              f_gnt,
  output logic              f_done,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_bytes,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_bytes,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rd_rdy,
  input  logic              mem_wr_rdy
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state_q, state_d;
  owner_t        owner_q, last_q;
  owner_t        pick_owner;
  logic          pick_valid;
  logic          we_q;
  logic [CW-1:0] cnt_q;
  logic          complete, expire, finish;
  logic [DATA_W-1:0] rd_val;

  mem_arb_pick u_pick (
    .f_req       (f_req),
    .d_req       (d_req),
    .last        (last_q),
    .grant_valid (pick_valid),
    .owner       (pick_owner)
  );

  // The opposite-direction ready pulse never completes a transfer.
  assign complete = we_q ? mem_wr_rdy : mem_rd_rdy;
  assign expire   = (TIMEOUT != 0) &&
                    (cnt_q == CW'(TIMEOUT - 1));
  assign finish   = complete | expire;
  assign rd_val   = (complete && !we_q) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = BUSY;
      BUSY:    if (finish) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q   <= OWN_FETCH;
      last_q    <= OWN_DATA;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      f_gnt     <= 1'b0;
      f_done    <= 1'b0;
      f_rdata   <= '0;
      f_err     <= 1'b0;
      d_gnt     <= 1'b0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
      mem_bytes <= '0;
    end else begin
      f_gnt  <= 1'b0;
      d_gnt  <= 1'b0;
      f_done <= 1'b0;
      d_done <= 1'b0;
      unique case (state_q)
        IDLE: if (pick_valid) begin
          owner_q <= pick_owner;
          last_q  <= pick_owner;
          cnt_q   <= '0;
          if (pick_owner == OWN_FETCH) begin
            f_gnt     <= 1'b1;
            we_q      <= 1'b0;
            mem_addr  <= f_addr;
            mem_bytes <= f_bytes;
            mem_wdata <= '0;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
          end else begin
            d_gnt     <= 1'b1;
            we_q      <= d_we;
            mem_addr  <= d_addr;
            mem_bytes <= d_bytes;
            mem_wdata <= d_wdata;
            mem_read  <= !d_we;
            mem_write <= d_we;
          end
        end
        BUSY: if (finish) begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (owner_q == OWN_FETCH) begin
            f_done  <= 1'b1;
            f_rdata <= rd_val;
            f_err   <= !complete;
          end else begin
            d_done  <= 1'b1;
            d_rdata <= rd_val;
            d_err   <= !complete;
          end
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
